// File: rtl/hs_tx_arbiter.sv
// hs_tx_arbiter: TX-side scheduler that shares one req/ack crossing channel
// between NUM_SRC producers. A round-robin pick captures one word, a full
// 4-phase req/ack cycle carries it across, then the channel is released.
// A missing ack is flagged (sticky) and recovered via a REQ-state timeout.
module hs_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*BUS_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         req,
  output logic [BUS_WIDTH-1:0]         tx_data,
  input  logic                         ack_sync,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         err_clr
);

  localparam int GW = $clog2(NUM_SRC);
  // The REQ counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE
  } state_t;

  state_t                 state_reg, state_next;
  logic                   req_reg, req_next;
  logic [BUS_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic [GW-1:0]          grant_reg, grant_next;
  logic [GW-1:0]          ptr_reg, ptr_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   err_reg, err_next;
  logic                   err_set;

  logic [BUS_WIDTH-1:0]   src_word [NUM_SRC];
  logic [GW-1:0]          cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0]     cand_hit;
  logic [GW-1:0]          winner;
  logic                   accept;

  // Candidate gi is the source gi positions after the round-robin pointer,
  // so candidate 0 is the highest-priority slot this round.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rr
    logic [GW:0] sum;
    assign sum           = {1'b0, ptr_reg} + (GW+1)'(gi);
    assign cand_idx[gi]  = (sum >= (GW+1)'(NUM_SRC)) ? GW'(sum - (GW+1)'(NUM_SRC)) : sum[GW-1:0];
    assign cand_hit[gi]  = src_valid[cand_idx[gi]];
    assign src_word[gi]  = src_data[gi*BUS_WIDTH +: BUS_WIDTH];
    assign src_ready[gi] = accept && (winner == GW'(gi));
  end

  // Pick the first valid candidate in rotated order (lowest offset wins).
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  // A stale ack still high in IDLE blocks any new accept.
  assign accept = (state_reg == ST_IDLE) && !ack_sync && (|src_valid);

  // Next-state and next-register values for the handshake sequence.
  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    tx_data_next = tx_data_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    err_set      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          tx_data_next = src_word[winner];
          grant_next   = winner;
          ptr_next     = (winner == GW'(NUM_SRC - 1)) ? '0 : winner + GW'(1);
          req_next     = 1'b1;
          cnt_next     = '0;
          state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          req_next   = 1'b0;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          // Abort drops the word; the producer is not retried.
          if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
            err_set    = 1'b1;
            req_next   = 1'b0;
            state_next = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (!ack_sync) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
    // Setting the flag takes priority over a simultaneous clear.
    err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);
  end

  // State and datapath registers; reset drops req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      req_reg     <= 1'b0;
      tx_data_reg <= '0;
      grant_reg   <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      tx_data_reg <= tx_data_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
    end
  end

  assign req         = req_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// tb_hs_tx_arbiter: scoreboard bench. Each round the reference model lists
// the grant order (cyclic scan of the valid set from the model pointer) and
// the expected req length / error flag for each transfer; an ack responder
// replays the planned ack delays and a monitor checks every transfer.
module tb_hs_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           req;
  logic [W-1:0]   tx_data;
  logic           ack_sync;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;
  logic           err_clr;
  logic           force_ack;
  logic           resp_ack;

  assign ack_sync = force_ack | resp_ack;

  hs_tx_arbiter #(.NUM_SRC(N), .BUS_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .req         (req),
    .tx_data     (tx_data),
    .ack_sync    (ack_sync),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  typedef struct {
    int         id;
    logic [W-1:0] data;
    int         req_cycles;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_total = 0;
  int   mon_done  = 0;
  int   m_ptr     = 0;
  bit   err_acc   = 1'b0;
  bit   mon_en    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per accept strobe, follows the transfer
  // through REQ and checks it on the first cycle req is low again.
  initial begin
    bit   in_xfer;
    exp_t cur;
    int   req_cnt;
    bit   data_ok, gid_ok, busy_ok;
    in_xfer = 1'b0;
    req_cnt = 0;
    data_ok = 1'b1;
    gid_ok  = 1'b1;
    busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_xfer = 1'b0;
      end else if (!in_xfer) begin
        if (src_ready != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_accept", 32'(src_ready), 32'h0);
          end else begin
            cur = exp_q.pop_front();
            chk("src_ready_onehot", 32'(src_ready), 32'h1 << cur.id);
            in_xfer = 1'b1;
            req_cnt = 0;
            data_ok = 1'b1;
            gid_ok  = 1'b1;
            busy_ok = 1'b1;
          end
        end
      end else begin
        if (src_ready != '0) chk("ready_during_xfer", 32'(src_ready), 32'h0);
        if (req) begin
          req_cnt++;
          if (tx_data !== cur.data) data_ok = 1'b0;
          if (grant_id !== 2'(cur.id)) gid_ok = 1'b0;
          if (busy !== 1'b1) busy_ok = 1'b0;
          if (req_cnt > 40) begin
            chk("req_stuck", 32'(req_cnt), 32'(cur.req_cycles));
            in_xfer = 1'b0;
            mon_done++;
          end
        end else begin
          chk("req_cycles", 32'(req_cnt), 32'(cur.req_cycles));
          chk("tx_data_stable", 32'(data_ok), 32'h1);
          chk("tx_data", 32'(tx_data), 32'(cur.data));
          chk("grant_id", 32'(grant_id), 32'(cur.id));
          chk("grant_stable", 32'(gid_ok), 32'h1);
          chk("busy_in_xfer", 32'(busy_ok && busy), 32'h1);
          chk("timeout_err", 32'(timeout_err), 32'(cur.err));
          $display("xfer src=%0d data=%02h req_cycles=%0d err=%0b", cur.id, cur.data, req_cnt, timeout_err);
          in_xfer = 1'b0;
          mon_done++;
        end
      end
    end
  end

  // Ack responder: raises ack during REQ cycle d (d from the plan) if req
  // is still up, then drops it a random 0..3 cycles after req falls.
  initial begin
    int d;
    int k;
    int guard;
    bit ok;
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !rst) begin
        if (ack_q.size() == 0) begin
          chk("ack_plan_underflow", 32'(ack_q.size()), 32'h1);
          d = 0;
        end else begin
          d = ack_q.pop_front();
        end
        k  = 0;
        ok = 1'b1;
        while (k < d) begin
          @(negedge clk);
          k++;
          if (!req) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          resp_ack = 1'b1;
          guard = 0;
          while (req && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          resp_ack = 1'b0;
        end
      end
    end
  end

  // One round: model computes grant order and outcomes, then the valid set
  // is presented and each source drops its valid once it has been accepted.
  task automatic run_round(input logic [N-1:0] mask, input int dfix, input int fdata, input int stale);
    exp_t       e;
    int         i;
    int         d;
    int         last;
    int         guard;
    logic [N-1:0] rdy;
    logic [W-1:0] words [N];
    last = m_ptr;
    for (int s = 0; s < N; s++) words[s] = 8'($urandom_range(0, 255));
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (mask[i]) begin
        d = (dfix >= 0) ? dfix : int'($urandom_range(0, 11));
        e.id = i;
        e.data = (fdata >= 0) ? 8'(fdata) : words[i];
        e.req_cycles = (d < TO) ? d + 1 : TO;
        if (d >= TO) err_acc = 1'b1;
        e.err = err_acc;
        words[i] = e.data;
        exp_q.push_back(e);
        ack_q.push_back(d);
        exp_total++;
        last = i;
      end
    end
    m_ptr = (last + 1) % N;

    if (stale > 0) repeat (5) @(posedge clk);
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) src_data[s*W +: W] = words[s];
    if (stale > 0) begin
      force_ack = 1'b1;
      src_valid = mask;
      repeat (stale) begin
        @(negedge clk);
        chk("stale_ack_no_ready", 32'(src_ready), 32'h0);
      end
      chk("stale_ack_idle", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      force_ack = 1'b0;
    end else begin
      src_valid = mask;
    end

    guard = 0;
    while (src_valid != '0 && guard < 300) begin
      @(negedge clk);
      rdy = src_ready;
      @(posedge clk);
      #1;
      src_valid = src_valid & ~rdy;
      for (int s = 0; s < N; s++) begin
        if (rdy[s]) src_data[s*W +: W] = 8'($urandom_range(0, 255));
      end
      guard++;
    end
    if (guard >= 300) chk("round_served", 32'(src_valid), 32'h0);

    guard = 0;
    while (mon_done != exp_total && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("scoreboard_drain", 32'(mon_done), 32'(exp_total));
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_acc = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(timeout_err), 32'h0);
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    force_ack = 1'b0;
    err_clr   = 1'b0;
    src_valid = '0;
    src_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single source 2, ack 3 cycles after req.
    run_round(4'b0100, 2, 'hA5, 0);
    // All sources pending, round-robin order.
    run_round(4'b1111, -1, -1, 0);
    run_round(4'b1111, -1, -1, 0);
    // Pointer set to 1, then sources 3 and 0 pending.
    run_round(4'b0001, 1, -1, 0);
    run_round(4'b1001, 1, -1, 0);
    // Ack never arrives: timeout after TO req cycles, then clear.
    run_round(4'b0010, 20, -1, 0);
    chk("err_sticky", 32'(timeout_err), 32'h1);
    pulse_clr();
    // Ack on the last allowed REQ cycle, and immediate ack.
    run_round(4'b0100, 7, -1, 0);
    run_round(4'b1000, 0, -1, 0);
    // Stale ack held in IDLE with valid pending.
    run_round(4'b0011, -1, -1, 4);
    // Timeout while err_clr held: set wins, then clear takes effect.
    err_clr = 1'b1;
    run_round(4'b0001, 20, -1, 0);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_acc = 1'b0;
    @(negedge clk);
    chk("err_clr_after_set", 32'(timeout_err), 32'h0);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      run_round(4'($urandom_range(1, 15)), -1, -1, (r % 5 == 0) ? 3 : 0);
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    // Reset in the middle of REQ, with the error flag set beforehand.
    run_round(4'b0001, 20, -1, 0);
    chk("err_before_rst", 32'(timeout_err), 32'h1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    ack_q.push_back(20);
    src_data[15:8] = 8'h3C;
    src_valid = 4'b0010;
    guard = 0;
    @(negedge clk);
    while (src_ready == '0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_test_accept", 32'(src_ready), 32'h2);
    @(posedge clk);
    #1;
    src_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_test_req_high", 32'(req), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_timeout_err", 32'(timeout_err), 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ptr   = 0;
    err_acc = 1'b0;
    mon_en  = 1'b1;
    // Pointer back at 0 after reset.
    run_round(4'b1111, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
